// File: rtl/msb_expand_pkg.sv
// Shared definitions for the MSB-position denormalizer: widths, the shift
// class enum, the stage-1 record and the exponent decode helper.
package msb_expand_pkg;

  localparam int DATA_W      = 24;
  localparam int EXP_W       = 5;
  localparam int EXP_MAX     = 23;
  localparam int MANT_W_DFLT = 12;
  localparam int SHIFT_W     = 5;

  typedef enum logic [1:0] {
    CLS_LEFT  = 2'd0,
    CLS_RIGHT = 2'd1,
    CLS_SAT   = 2'd2
  } shift_cls_e;

  typedef struct packed {
    logic [MANT_W_DFLT-1:0] mant;
    logic [SHIFT_W-1:0]     shift;
    shift_cls_e             cls;
  } s1_rec_t;

  // Decode an exponent into shift direction and magnitude relative to the
  // mantissa MSB (bit MANT_W_DFLT-1 maps to output bit 'exp').
  function automatic s1_rec_t decode(input logic [MANT_W_DFLT-1:0] mant,
                                     input logic [EXP_W-1:0]       exp);
    s1_rec_t          rec;
    logic signed [5:0] d;
    d         = $signed({1'b0, exp}) - $signed(6'(MANT_W_DFLT - 1));
    rec.mant  = mant;
    rec.shift = 5'd0;
    rec.cls   = CLS_LEFT;
    if (exp > 5'(EXP_MAX)) begin
      rec.cls = CLS_SAT;
    end else if (d >= 6'sd0) begin
      rec.cls   = CLS_LEFT;
      rec.shift = 5'(d);
    end else begin
      rec.cls   = CLS_RIGHT;
      rec.shift = 5'(-d);
    end
    return rec;
  endfunction

endpackage

// File: rtl/msb_expand_shift.sv
// Combinational stage-2 datapath: barrel shift with round-half-up on right
// shifts, and all-ones saturation.
module msb_expand_shift
  import msb_expand_pkg::*;
(
  input  s1_rec_t           rec,
  output logic [DATA_W-1:0] data,
  output logic              sat
);

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] rnd;

  // Rebuild the magnitude from the decoded record.
  always_comb begin
    ext  = {{(DATA_W-MANT_W_DFLT){1'b0}}, rec.mant};
    rnd  = {DATA_W{1'b0}};
    data = {DATA_W{1'b0}};
    sat  = 1'b0;
    case (rec.cls)
      CLS_LEFT: begin
        data = ext << rec.shift;
      end
      CLS_RIGHT: begin
        // Right shifts are always >= 1, so shift-1 never underflows.
        rnd  = ONE << (rec.shift - 5'd1);
        data = (ext + rnd) >> rec.shift;
      end
      CLS_SAT: begin
        data = {DATA_W{1'b1}};
        sat  = 1'b1;
      end
      default: begin
        data = {DATA_W{1'b0}};
        sat  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/msb_expand.sv
// Denormalizer top: two-stage valid/ready pipeline (decode, shift) with
// frame counting and per-frame saturation counting.
module msb_expand #(
  parameter int MANT_W    = 12,
  parameter int DATA_W    = 24,
  parameter int FRAME_LEN = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [4:0]        in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_sat,
  output logic [15:0]       sat_count
);

  import msb_expand_pkg::*;

  localparam int              CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  logic              s1_valid_q, s1_valid_d;
  s1_rec_t           s1_rec_q, s1_rec_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sat_q, out_sat_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [15:0]       sat_count_q, sat_count_d;
  logic              new_frame_q, new_frame_d;

  logic              out_xfer_s, s2_load_s, s1_advance_s, in_ready_s, is_last_s;
  logic [DATA_W-1:0] shift_data_s;
  logic              shift_sat_s;

  msb_expand_shift u_shift (
    .rec  (s1_rec_q),
    .data (shift_data_s),
    .sat  (shift_sat_s)
  );

  // Handshake: a stage loads when empty or when its contents leave this cycle.
  always_comb begin
    out_xfer_s   = out_valid_q & out_ready;
    s2_load_s    = ~out_valid_q | out_ready;
    s1_advance_s = s1_valid_q & s2_load_s;
    in_ready_s   = ~s1_valid_q | s1_advance_s;
    is_last_s    = (frame_cnt_q == CNT_LAST);
  end

  // Next state of both pipeline stages.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_rec_d    = s1_rec_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (in_ready_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_rec_d = decode(in_mant, in_exp);
      end else begin
        s1_rec_d = s1_rec_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_load_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = shift_data_s;
        out_sat_d  = shift_sat_s;
      end else begin
        out_data_d = out_data_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Frame position and saturation count, both advanced by output transfers.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    sat_count_d = sat_count_q;
    new_frame_d = new_frame_q;
    if (out_xfer_s) begin
      frame_cnt_d = is_last_s ? {CNT_W{1'b0}} : frame_cnt_q + CNT_W'(1);
      new_frame_d = is_last_s;
      if (new_frame_q) begin
        sat_count_d = {15'd0, out_sat_q};
      end else if (out_sat_q && (sat_count_q != 16'hFFFF)) begin
        sat_count_d = sat_count_q + 16'd1;
      end else begin
        sat_count_d = sat_count_q;
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_rec_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_sat_q   <= 1'b0;
      frame_cnt_q <= {CNT_W{1'b0}};
      sat_count_q <= 16'd0;
      new_frame_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_rec_q    <= s1_rec_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      frame_cnt_q <= frame_cnt_d;
      sat_count_q <= sat_count_d;
      new_frame_q <= new_frame_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_last  = out_valid_q & is_last_s;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_msb_expand.sv
// Self-checking bench for msb_expand with a short frame length.
module tb_msb_expand;

  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_mant = 12'd0;
  logic [4:0]  in_exp = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_data;
  logic        out_last;
  logic        out_sat;
  logic [15:0] sat_count;

  int n_checks = 0;
  int n_fail   = 0;

  // observations taken #1 after the falling edge of each driven cycle
  logic        ob_in_x, ob_out_x, ob_in_ready, ob_out_valid, ob_sat, ob_last;
  logic [23:0] ob_data;
  logic [15:0] ob_satcnt;

  // reference model state
  logic [24:0] exp_q[$];
  int          m_cnt;
  logic [15:0] m_sat;
  bit          m_new;

  msb_expand #(.MANT_W(12), .DATA_W(24), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_sat(out_sat), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] ref_model(input int mant, input int e);
    int v;
    if (e > 23) return {1'b1, 24'hFFFFFF};
    if (e >= 11) v = mant << (e - 11);
    else         v = (mant + (1 << (10 - e))) >> (11 - e);
    return {1'b0, v[23:0]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_cnt = 0;
    m_sat = 16'd0;
    m_new = 1'b0;
  endtask

  // Consume the oldest expected sample; sc is the count visible before it.
  task automatic model_pop(output logic [23:0] d, output logic s,
                           output logic l, output logic [15:0] sc);
    {s, d} = exp_q.pop_front();
    l  = (m_cnt == FL - 1);
    sc = m_sat;
    if (m_new) m_sat = s ? 16'd1 : 16'd0;
    else if (s && m_sat != 16'hFFFF) m_sat = m_sat + 16'd1;
    m_new = l;
    m_cnt = l ? 0 : m_cnt + 1;
  endtask

  task automatic cyc(input logic v, input logic [11:0] m, input logic [4:0] e,
                     input logic r);
    @(negedge clk);
    in_valid = v; in_mant = m; in_exp = e; out_ready = r;
    #1;
    ob_in_ready  = in_ready;
    ob_out_valid = out_valid;
    ob_in_x      = in_valid & in_ready;
    ob_out_x     = out_valid & out_ready;
    ob_data      = out_data;
    ob_sat       = out_sat;
    ob_last      = out_last;
    ob_satcnt    = sat_count;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({out_valid, out_data, out_last, out_sat, sat_count, in_ready} !==
        {1'b0, 24'h0, 1'b0, 1'b0, 16'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: got valid=%b data=%h last=%b sat=%b satcnt=%0d rdy=%b, want 0 0 0 0 0 1",
               out_valid, out_data, out_last, out_sat, sat_count, in_ready);
    end
  endtask

  task automatic test_directed();
    logic [11:0] mants [7] = '{12'h800, 12'hABC, 12'hFFF, 12'h800, 12'h000, 12'h123, 12'hFFF};
    logic [4:0]  exps  [7] = '{5'd11, 5'd23, 5'd5, 5'd0, 5'd9, 5'd24, 5'd31};
    logic [23:0] wants [7] = '{24'h000800, 24'hABC000, 24'h000040, 24'h000001,
                               24'h000000, 24'hFFFFFF, 24'hFFFFFF};
    logic        wsat  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [23:0] ed; logic es, el; logic [15:0] esc;
    int sent = 0, got = 0;
    // latency: presented in cycle 0, visible in cycle 2
    cyc(1'b1, 12'h800, 5'd11, 1'b1);
    n_checks++;
    if (ob_in_x !== 1'b1) begin n_fail++; $display("FAIL lat_accept: got %b want 1", ob_in_x); end
    exp_q.push_back(ref_model(12'h800, 11));
    cyc(1'b0, 12'h000, 5'd0, 1'b1);
    n_checks++;
    if (ob_out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early: out_valid got %b want 0", ob_out_valid); end
    cyc(1'b0, 12'h000, 5'd0, 1'b1);
    n_checks++;
    if ({ob_out_valid, ob_data, ob_sat} !== {1'b1, 24'h000800, 1'b0}) begin
      n_fail++; $display("FAIL lat_pass: got v=%b d=%h s=%b want 1 000800 0", ob_out_valid, ob_data, ob_sat);
    end
    if (ob_out_x) model_pop(ed, es, el, esc);
    for (int c = 0; c < 40 && got < 7; c++) begin
      cyc(sent < 7, mants[sent % 7], exps[sent % 7], 1'b1);
      n_checks++;
      if (ob_in_ready !== 1'b1) begin n_fail++; $display("FAIL dir_ready: got %b want 1", ob_in_ready); end
      if (ob_out_x) begin
        model_pop(ed, es, el, esc);
        n_checks++;
        if ({ob_data, ob_sat, ob_last, ob_satcnt} !== {wants[got], wsat[got], el, esc}) begin
          n_fail++;
          $display("FAIL dir_out[%0d]: got d=%h s=%b l=%b sc=%0d want d=%h s=%b l=%b sc=%0d",
                   got, ob_data, ob_sat, ob_last, ob_satcnt, wants[got], wsat[got], el, esc);
        end
        got++;
      end
      if (ob_in_x) begin
        exp_q.push_back(ref_model(int'(mants[sent]), int'(exps[sent])));
        sent++;
      end
    end
    n_checks++;
    if (got != 7) begin n_fail++; $display("FAIL dir_timeout: got %0d outputs want 7", got); end
  endtask

  task automatic test_backpressure();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [23:0] ed, pd; logic es, el, ps, pl, r, want_rdy, pstall; logic [15:0] esc;
    logic [11:0] m; logic [4:0] e;
    int sent = 0, got = 0;
    pstall = 1'b0; pd = 24'h0; ps = 1'b0; pl = 1'b0;
    for (int c = 0; c < 200 && got < 10; c++) begin
      r = pat[c % 4];
      m = 12'($urandom_range(0, 4095));
      e = 5'($urandom_range(0, 31));
      cyc(sent < 10, m, e, r);
      want_rdy = !(exp_q.size() == 2 && !r);
      n_checks++;
      if (ob_in_ready !== want_rdy) begin
        n_fail++; $display("FAIL bp_ready: got %b want %b (inflight=%0d)", ob_in_ready, want_rdy, exp_q.size());
      end
      if (pstall) begin
        n_checks++;
        if ({ob_out_valid, ob_data, ob_sat, ob_last} !== {1'b1, pd, ps, pl}) begin
          n_fail++; $display("FAIL bp_stable: got v=%b d=%h s=%b l=%b want 1 %h %b %b",
                             ob_out_valid, ob_data, ob_sat, ob_last, pd, ps, pl);
        end
      end
      pstall = ob_out_valid & !r; pd = ob_data; ps = ob_sat; pl = ob_last;
      if (ob_out_x) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra: unexpected output d=%h", ob_data);
        end else begin
          model_pop(ed, es, el, esc);
          if ({ob_data, ob_sat, ob_last, ob_satcnt} !== {ed, es, el, esc}) begin
            n_fail++; $display("FAIL bp_out[%0d]: got d=%h s=%b l=%b sc=%0d want d=%h s=%b l=%b sc=%0d",
                               got, ob_data, ob_sat, ob_last, ob_satcnt, ed, es, el, esc);
          end
        end
        got++;
      end
      if (ob_in_x) begin exp_q.push_back(ref_model(int'(m), int'(e))); sent++; end
    end
    n_checks++;
    if (got != 10) begin n_fail++; $display("FAIL bp_timeout: got %0d outputs want 10", got); end
  endtask

  task automatic test_random();
    logic [23:0] ed; logic es, el, r, want_rdy; logic [15:0] esc;
    logic [11:0] m; logic [4:0] e;
    int sent = 0, got = 0;
    for (int c = 0; c < 3000 && got < 150; c++) begin
      r = ($urandom_range(0, 9) < 7);
      m = 12'($urandom_range(0, 4095));
      e = 5'($urandom_range(0, 31));
      cyc((sent < 150) && ($urandom_range(0, 9) < 7), m, e, r);
      want_rdy = !(exp_q.size() == 2 && !r);
      n_checks++;
      if (ob_in_ready !== want_rdy) begin
        n_fail++; $display("FAIL rnd_ready: got %b want %b", ob_in_ready, want_rdy);
      end
      if (ob_out_x) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra: unexpected output d=%h", ob_data);
        end else begin
          model_pop(ed, es, el, esc);
          if ({ob_data, ob_sat, ob_last, ob_satcnt} !== {ed, es, el, esc}) begin
            n_fail++; $display("FAIL rnd_out[%0d]: got d=%h s=%b l=%b sc=%0d want d=%h s=%b l=%b sc=%0d",
                               got, ob_data, ob_sat, ob_last, ob_satcnt, ed, es, el, esc);
          end
        end
        got++;
      end
      if (ob_in_x) begin exp_q.push_back(ref_model(int'(m), int'(e))); sent++; end
    end
    n_checks++;
    if (got != 150) begin n_fail++; $display("FAIL rnd_timeout: got %0d outputs want 150", got); end
  endtask

  task automatic test_framing();
    // saturated samples at transfers 1,2,3 (frame 1) and 9 (first of frame 3)
    logic [4:0] exps [9] = '{5'd24, 5'd31, 5'd25, 5'd12, 5'd3, 5'd30, 5'd20, 5'd11, 5'd27};
    logic [23:0] ed; logic es, el; logic [15:0] esc;
    logic [11:0] m;
    int sent = 0, got = 0;
    exps[5] = 5'd7;  // keep frame 2 free of saturation
    do_reset();
    for (int c = 0; c < 60 && got < 9; c++) begin
      m = 12'($urandom_range(0, 4095));
      cyc(sent < 9, m, exps[sent % 9], 1'b1);
      if (ob_out_x) begin
        model_pop(ed, es, el, esc);
        got++;
        n_checks++;
        if ({ob_data, ob_sat, ob_last, ob_satcnt} !== {ed, es, el, esc} ||
            ob_last !== (got == 4 || got == 8)) begin
          n_fail++; $display("FAIL frm_out[%0d]: got d=%h s=%b l=%b sc=%0d want d=%h s=%b l=%b sc=%0d",
                             got, ob_data, ob_sat, ob_last, ob_satcnt, ed, es, (got == 4 || got == 8), esc);
        end
        if (got == 4) begin
          n_checks++;
          if (ob_satcnt !== 16'd3) begin n_fail++; $display("FAIL frm_sat3: got %0d want 3", ob_satcnt); end
        end
        if (got == 6) begin
          n_checks++;
          if (ob_satcnt !== 16'd0) begin n_fail++; $display("FAIL frm_clear: got %0d want 0", ob_satcnt); end
        end
      end
      if (ob_in_x) begin exp_q.push_back(ref_model(int'(m), int'(exps[sent]))); sent++; end
    end
    cyc(1'b0, 12'h000, 5'd0, 1'b1);
    n_checks++;
    if (got != 9 || ob_satcnt !== 16'd1 || ob_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL frm_end: got n=%0d sc=%0d v=%b want n=9 sc=1 v=0", got, ob_satcnt, ob_out_valid);
    end
  endtask

  task automatic test_reset_stall();
    logic [23:0] ed; logic es, el; logic [15:0] esc;
    logic [11:0] m;
    int sent = 0, got = 0;
    cyc(1'b1, 12'h111, 5'd26, 1'b0);
    cyc(1'b1, 12'h222, 5'd28, 1'b0);
    cyc(1'b0, 12'h000, 5'd0, 1'b0);
    n_checks++;
    if (ob_out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre: out_valid got %b want 1", ob_out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_last, out_sat, sat_count, in_ready} !== {1'b0, 1'b0, 1'b0, 16'd0, 1'b1}) begin
      n_fail++; $display("FAIL rst_async: got v=%b l=%b s=%b sc=%0d rdy=%b want 0 0 0 0 1",
                         out_valid, out_last, out_sat, sat_count, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 40 && got < 4; c++) begin
      m = 12'($urandom_range(0, 4095));
      cyc(sent < 4, m, 5'd14, 1'b1);
      if (ob_out_x) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rst_extra: stale output d=%h", ob_data);
        end else begin
          model_pop(ed, es, el, esc);
          got++;
          if ({ob_data, ob_sat, ob_last, ob_satcnt} !== {ed, es, el, esc} || ob_last !== (got == 4)) begin
            n_fail++; $display("FAIL rst_out[%0d]: got d=%h s=%b l=%b sc=%0d want d=%h s=%b l=%b sc=%0d",
                               got, ob_data, ob_sat, ob_last, ob_satcnt, ed, es, (got == 4), esc);
          end
        end
      end
      if (ob_in_x) begin exp_q.push_back(ref_model(int'(m), 14)); sent++; end
    end
    n_checks++;
    if (got != 4) begin n_fail++; $display("FAIL rst_timeout: got %0d outputs want 4", got); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_framing();
    test_reset_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
